// File: rtl/shreg_pkg.sv
// Shared constants for the universal shift register: the mode encoding used on the mode port.
package shreg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage : shreg_pkg

// File: rtl/shreg_cnt.sv
// Shift counter for univ_shift_reg. Counts increments modulo WIDTH and pulses o_done for one
// cycle on the increment that wraps the count back to zero. A clear discards the partial count.
module shreg_cnt #(
  parameter int unsigned  WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done_next;

  // Next count: clear beats increment, so a load on the wrap cycle issues no done pulse.
  always_comb begin
    w_cnt_next  = r_cnt;
    w_done_next = 1'b0;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_inc) begin
      if (r_cnt == LAST) begin
        w_cnt_next  = '0;
        w_done_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  // Count and done registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_done <= w_done_next;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = r_done;

endmodule : shreg_cnt

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, shift right, shift left, parallel load, with both serial
// ends exposed for chaining and a shift counter that pulses cnt_done every WIDTH shifts.
// Optional feature macro SHREG_ROTATE_EN: adds the rot port; rot=1 makes shifts rotate.
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_msb,
  input  logic             sin_lsb,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             cnt_done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_msb_in;
  logic             w_lsb_in;
  logic             w_shift;
  logic             w_load;

  // Bits entering the register on a shift: serial inputs, or the opposite end when rotating.
`ifdef SHREG_ROTATE_EN
  assign w_msb_in = rot ? r_q[0]       : sin_msb;
  assign w_lsb_in = rot ? r_q[WIDTH-1] : sin_lsb;
`else
  assign w_msb_in = sin_msb;
  assign w_lsb_in = sin_lsb;
`endif

  // Decode the mode into the next register value and the counter controls.
  always_comb begin
    w_q_next = r_q;
    w_shift  = 1'b0;
    w_load   = 1'b0;
    unique case (mode)
      MODE_HOLD: w_q_next = r_q;
      MODE_SHR: begin
        w_q_next = {w_msb_in, r_q[WIDTH-1:1]};
        w_shift  = 1'b1;
      end
      MODE_SHL: begin
        w_q_next = {r_q[WIDTH-2:0], w_lsb_in};
        w_shift  = 1'b1;
      end
      MODE_LOAD: begin
        w_q_next = d;
        w_load   = 1'b1;
      end
      default: w_q_next = r_q;
    endcase
  end

  // Data register; reset overrides any mode in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_q_next;
    end
  end

  shreg_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_shift),
    .i_clr   (w_load),
    .o_cnt   (shift_cnt),
    .o_done  (cnt_done)
  );

  assign q        = r_q;
  assign sout_msb = r_q[WIDTH-1];
  assign sout_lsb = r_q[0];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): directed vector table,
// hand-written multi-cycle sequences and randomized stimulus against a reference model.
module tb_univ_shift_reg;
  import shreg_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         sin_msb;
  logic         sin_lsb;
`ifdef SHREG_ROTATE_EN
  logic         rot;
`endif
  logic [W-1:0] q;
  logic         sout_msb;
  logic         sout_lsb;
  logic [2:0]   shift_cnt;
  logic         cnt_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(
    .WIDTH     (W),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .d         (d),
    .sin_msb   (sin_msb),
    .sin_lsb   (sin_lsb),
`ifdef SHREG_ROTATE_EN
    .rot       (rot),
`endif
    .q         (q),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .shift_cnt (shift_cnt),
    .cnt_done  (cnt_done)
  );

  typedef struct {
    logic         rst;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         smsb;
    logic         slsb;
    logic [W-1:0] eq;
    logic [2:0]   ec;
    logic         ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] m, logic [W-1:0] dd, logic sm, logic sl,
                              logic [W-1:0] eq, logic [2:0] ec, logic ed);
    vec_t v;
    v.rst = r; v.mode = m; v.d = dd; v.smsb = sm; v.slsb = sl;
    v.eq = eq; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] m, input logic [W-1:0] dd,
                       input logic sm, input logic sl);
    reset = r; mode = m; d = dd; sin_msb = sm; sin_lsb = sl;
  endtask

  // Reference model state: value as plain integer, shifts taken since last load/reset/wrap.
  int unsigned m_q;
  int unsigned m_n;
  bit          m_done;

  initial begin
    int pulses;
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
`ifdef SHREG_ROTATE_EN
    rot = 1'b0;
`endif
    #2;

    // ---------------- directed vector table ----------------
    vecs.push_back(mk(1, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0, 0));  // reset
    vecs.push_back(mk(0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(mk(0, MODE_HOLD, 8'hFF, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(mk(0, MODE_HOLD, 8'h3C, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h52, 1, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h29, 2, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h14, 3, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h0A, 4, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h05, 5, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h02, 6, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h01, 7, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h00, 0, 1));  // 8th shift wraps
    vecs.push_back(mk(0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0, 0));  // pulse lasts one cycle
    vecs.push_back(mk(0, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, MODE_SHL,  8'h00, 0, 1, 8'h03, 1, 0));
    vecs.push_back(mk(0, MODE_SHL,  8'h00, 0, 0, 8'h06, 2, 0));
    vecs.push_back(mk(0, MODE_SHL,  8'h00, 0, 0, 8'h0C, 3, 0));
    vecs.push_back(mk(0, MODE_SHL,  8'h00, 0, 0, 8'h18, 4, 0));
    vecs.push_back(mk(0, MODE_SHL,  8'h00, 0, 0, 8'h30, 5, 0));
    vecs.push_back(mk(0, MODE_SHL,  8'h00, 0, 0, 8'h60, 6, 0));
    vecs.push_back(mk(1, MODE_SHL,  8'h00, 0, 1, 8'h00, 0, 0));  // reset beats shift
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 1, 0, 8'h80, 1, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 1, 0, 8'hC0, 2, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 1, 0, 8'hE0, 3, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 1, 0, 8'hF0, 4, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 1, 0, 8'hF8, 5, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 1, 0, 8'hFC, 6, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 1, 0, 8'hFE, 7, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 1, 0, 8'hFF, 0, 1));
    vecs.push_back(mk(0, MODE_HOLD, 8'h00, 0, 0, 8'hFF, 0, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h7F, 1, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h3F, 2, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h1F, 3, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h0F, 4, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h07, 5, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h03, 6, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 0, 0, 8'h01, 7, 0));
    vecs.push_back(mk(0, MODE_LOAD, 8'h5A, 0, 0, 8'h5A, 0, 0));  // load on wrap cycle
    vecs.push_back(mk(0, MODE_HOLD, 8'h00, 0, 0, 8'h5A, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mode, vecs[i].d, vecs[i].smsb, vecs[i].slsb);
      step();
      check($sformatf("vec%0d q", i),        q,         vecs[i].eq);
      check($sformatf("vec%0d cnt", i),      shift_cnt, vecs[i].ec);
      check($sformatf("vec%0d done", i),     cnt_done,  vecs[i].ed);
      check($sformatf("vec%0d sout_msb", i), sout_msb,  vecs[i].eq[W-1]);
      check($sformatf("vec%0d sout_lsb", i), sout_lsb,  vecs[i].eq[0]);
    end

    // ---------------- mixed-direction shifts: 4 right + 4 left give one pulse ----------------
    drive(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
    step();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, (i < 4) ? MODE_SHR : MODE_SHL, 8'h00, 1'b1, 1'b1);
      step();
      if (cnt_done === 1'b1) pulses++;
      if (i == 6) check("mixed pre-wrap done", cnt_done, 1'b0);
    end
    check("mixed wrap done", cnt_done, 1'b1);
    check("mixed wrap cnt", shift_cnt, 3'd0);
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
    step();
    if (cnt_done === 1'b1) pulses++;
    check("mixed pulse count", pulses, 1);
    check("mixed q", q, 8'h0F);

    // ---------------- reset mid-sequence discards the partial count ----------------
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    step();
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b1);
      step();
      if (cnt_done === 1'b1) pulses++;
    end
    check("post-reset no early pulse", pulses, 0);
    check("post-reset cnt", shift_cnt, 3'd7);

`ifdef SHREG_ROTATE_EN
    // ---------------- rotate ----------------
    rot = 1'b1;
    drive(1'b0, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    step();
    drive(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0);
    step();
    check("rot shr q", q, 8'hC0);
    drive(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b0);
    step();
    step();
    check("rot shl2 q", q, 8'h03);
    drive(1'b0, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    step();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, MODE_SHR, 8'h00, 1'b1, 1'b1);
      step();
      if (cnt_done === 1'b1) pulses++;
    end
    check("rot8 q", q, 8'h81);
    check("rot8 pulses", pulses, 1);
    rot = 1'b0;
`endif

    // ---------------- randomized against reference model ----------------
    drive(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
    step();
    m_q = 0; m_n = 0; m_done = 0;
    for (int i = 0; i < 400; i++) begin
      int unsigned in_msb, in_lsb;
      logic        r;
      r = ($urandom_range(0, 19) == 0);
      drive(r, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom));
      in_msb = sin_msb;
      in_lsb = sin_lsb;
`ifdef SHREG_ROTATE_EN
      rot = 1'($urandom);
      if (rot) begin
        in_msb = m_q % 2;
        in_lsb = m_q / 128;
      end
`endif
      if (r) begin
        m_q = 0; m_n = 0; m_done = 0;
      end else begin
        m_done = 0;
        case (mode)
          MODE_SHR: begin m_q = in_msb * 128 + m_q / 2;       m_n++; end
          MODE_SHL: begin m_q = (m_q * 2) % 256 + in_lsb;     m_n++; end
          MODE_LOAD: begin m_q = int'(d); m_n = 0; end
          default: ;
        endcase
        if (m_n == W) begin
          m_n = 0;
          m_done = 1;
        end
      end
      step();
      check($sformatf("rnd%0d q", i),    q,         m_q);
      check($sformatf("rnd%0d cnt", i),  shift_cnt, m_n);
      check($sformatf("rnd%0d done", i), cnt_done,  m_done);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_univ_shift_reg
